// File: rtl/sec60_ctrl_if.sv
// Key inputs and counter-control outputs of the 60-second counter run-control front end.
// The controller takes the slave side; whatever drives the keys takes the master side.
interface sec60_ctrl_if;
    logic [1:0] KEY;
    logic       EN1HZ;
    logic       CLR;
    logic       RUN;
    logic       LAP;

    modport master (output KEY, input EN1HZ, CLR, RUN, LAP);
    modport slave  (input KEY, output EN1HZ, CLR, RUN, LAP);
endinterface

// File: rtl/sec60_ctrl.sv
// Start/pause/clear run control for the 60-second counter: key sync + debounce, FSM, 1 Hz gate.
// Optional lap/display-hold toggle is built only when SEC60_CTRL_LAP_EN is defined.
module sec60_ctrl #(
    parameter int unsigned SAMPLE_DIV = 500_000,
    parameter int unsigned TICK_DIV   = 50_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    sec60_ctrl_if.slave bus
);

    localparam int unsigned SW = $clog2(SAMPLE_DIV);
    localparam int unsigned TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    logic [1:0]       sync1_q, sync2_q;
    logic [SW-1:0]    samp_q;
    logic             samp_tick;
    logic [1:0][1:0]  hist_q;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       press;
    logic             start_p, clr_p;
    state_e           state_q, state_d;
    logic             clr_req;
    logic [TW-1:0]    presc_q, presc_d;
    logic             presc_wrap;
    logic             en_q, clr_q, run_q;

    assign samp_tick = (samp_q == SW'(SAMPLE_DIV - 1));

    // Keys idle high, so every key-path flop resets to the released level.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            samp_q  <= '0;
            hist_q  <= {2'b11, 2'b11};
            deb_q   <= 2'b11;
        end else begin
            sync1_q <= bus.KEY;
            sync2_q <= sync1_q;
            samp_q  <= samp_tick ? '0 : samp_q + SW'(1);
            if (samp_tick) begin
                for (int k = 0; k < 2; k++) begin
                    hist_q[k] <= {hist_q[k][0], sync2_q[k]};
                end
            end
            deb_q <= deb_d;
        end
    end

    always_comb begin
        deb_d = deb_q;
        for (int k = 0; k < 2; k++) begin
            if (hist_q[k] == 2'b00) begin
                deb_d[k] = 1'b0;
            end else if (hist_q[k] == 2'b11) begin
                deb_d[k] = 1'b1;
            end
        end
    end

    assign press   = deb_q & ~deb_d;
    assign start_p = press[0];
    assign clr_p   = press[1];

`ifdef SEC60_CTRL_LAP_EN
    logic lap_tgl;
`endif

    // Clear has priority outside RUN; inside RUN start has priority.
    always_comb begin
        state_d = state_q;
        clr_req = 1'b0;
`ifdef SEC60_CTRL_LAP_EN
        lap_tgl = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (clr_p) begin
                    clr_req = 1'b1;
                end else if (start_p) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (start_p) begin
                    state_d = StPause;
                end
`ifdef SEC60_CTRL_LAP_EN
                else if (clr_p) begin
                    lap_tgl = 1'b1;
                end
`endif
            end
            StPause: begin
                if (clr_p) begin
                    state_d = StIdle;
                    clr_req = 1'b1;
                end else if (start_p) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign presc_wrap = (presc_q == TW'(TICK_DIV - 1));

    // Prescaler only advances in RUN so a pause keeps the partial second.
    always_comb begin
        presc_d = presc_q;
        if (clr_req) begin
            presc_d = '0;
        end else if (state_q == StRun) begin
            presc_d = presc_wrap ? '0 : presc_q + TW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            presc_q <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            en_q    <= (state_q == StRun) && presc_wrap;
            clr_q   <= clr_req;
            run_q   <= (state_d == StRun);
        end
    end

    assign bus.EN1HZ = en_q;
    assign bus.CLR   = clr_q;
    assign bus.RUN   = run_q;

`ifdef SEC60_CTRL_LAP_EN
    logic lap_q, lap_d;

    always_comb begin
        lap_d = lap_q;
        if ((state_d != StRun) || clr_req) begin
            lap_d = 1'b0;
        end else if (lap_tgl) begin
            lap_d = ~lap_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lap_q <= 1'b0;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign bus.LAP = lap_q;
`else
    assign bus.LAP = 1'b0;
`endif

endmodule

// File: doc/sec60_ctrl.md
Name: sec60_ctrl

Overview:
Run-control front end placed directly upstream of the 60-second counter on the DE0-CV board. It conditions the two push keys and runs a start/pause/clear state machine. It produces the gated 1 Hz count enable and a one-cycle clear pulse that the counter consumes in place of its free-running enable and reset. The DE0-CV clock is 50 MHz and the keys are active-low.

Parameters:
SAMPLE_DIV, 500_000, key sample period in CLK cycles (10 ms); must be at least 2.
TICK_DIV, 50_000_000, CLK cycles per count enable (1 s); must be at least 2.

Ports:
CLK  input  1  system clock, 50 MHz
RST  input  1  reset, asynchronous, active-high
KEY  input  2  raw push keys, active-low, asynchronous; KEY[0] = start/pause, KEY[1] = clear
EN1HZ  output  1  one-cycle count enable to the counter; only asserted while running
CLR  output  1  one-cycle synchronous clear pulse to the counter
RUN  output  1  level, high while in RUN
LAP  output  1  display-hold level; see Optional Feature

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high. Every flop is cleared asynchronously by RST.
- Reset values:
  - State = IDLE, prescaler = 0.
  - Synchronizer and debounce flops = 1 (keys released).
  - EN1HZ = 0, CLR = 0, RUN = 0, LAP = 0.
- Synchronizer: 2-flop synchronizer per KEY bit.
- Sample tick: a free-running counter runs 0..SAMPLE_DIV-1 and generates a one-cycle sample tick at SAMPLE_DIV-1, then wraps to 0.
- Debounce, per key:
  - On each sample tick, shift the synchronized bit into a 2-bit history.
  - The debounced level goes low when both history bits are 0, and goes high when both are 1. Otherwise it holds.
  - Press pulse = one cycle on the high-to-low transition of the debounced level. Release generates nothing.
- Press latency: from KEY going stably low to the press pulse is between SAMPLE_DIV+2 and 2*SAMPLE_DIV+3 cycles. Glitches shorter than one sample period never produce a pulse.
- FSM states: IDLE (stopped, counter cleared), RUN, PAUSE. Transitions are registered, effective the cycle after the press pulse.
  - IDLE: start press -> RUN. Clear press -> stay IDLE and pulse CLR.
  - RUN: start press -> PAUSE. Clear press is ignored (but see LAP_EN).
  - PAUSE: start press -> RUN. Clear press -> IDLE and pulse CLR.
- Simultaneous start and clear presses in the same cycle:
  - In IDLE or PAUSE, clear wins: go to IDLE and pulse CLR; start is dropped.
  - In RUN, start wins: go to PAUSE; clear is dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while in RUN. At TICK_DIV-1 it wraps to 0.
  - It holds its value in PAUSE, so the partial second is preserved across a pause.
  - It is forced to 0 in the same cycle that CLR is asserted.
- Output timing:
  - EN1HZ = (state==RUN && prescaler==TICK_DIV-1), registered so it is exactly one cycle wide.
  - The first EN1HZ after IDLE->RUN comes exactly TICK_DIV cycles after RUN rises.
  - CLR is one cycle wide and registered.
  - RUN is registered from the state.
- Reset mid-operation: asserting RST in any state returns all outputs to reset values immediately, without waiting for a clock edge. No EN1HZ or CLR pulse is issued on reset release.

Optional Feature:
- Macro: SEC60_CTRL_LAP_EN.
- Defined: a clear press while in RUN toggles LAP. Counting and EN1HZ are unaffected; the downstream display freezes while LAP=1.
  - LAP is forced to 0 on leaving RUN and whenever CLR is asserted.
  - With simultaneous presses in RUN, start wins: go to PAUSE and LAP is forced to 0.
- Undefined: a clear press in RUN is ignored, LAP is tied to 0, and no LAP logic is synthesized. The LAP port remains present.

Test Plan (bench uses SAMPLE_DIV=4, TICK_DIV=10):
1. Reset, then hold KEY=2'b11 for 200 cycles -> EN1HZ, CLR, RUN and LAP stay 0, and state stays IDLE.
2. Press KEY[0] low for 20 cycles -> RUN rises 6..12 cycles after the press. EN1HZ pulses exactly every 10 cycles, the first one 10 cycles after RUN rises.
3. In RUN, with the prescaler at 6, press KEY[0] -> RUN falls and EN1HZ stops. Press KEY[0] again -> the next EN1HZ arrives 3 cycles after RUN re-rises.
4. In PAUSE, press KEY[1] -> CLR is high for exactly 1 cycle and the state goes to IDLE. Press KEY[0] -> the first EN1HZ comes 10 cycles after RUN rises.
5. Press both keys together: in PAUSE -> CLR pulses and the state goes to IDLE. In RUN -> the state goes to PAUSE with no CLR. Also inject 1-cycle KEY glitches -> no press is detected.
6. With SEC60_CTRL_LAP_EN defined, press KEY[1] in RUN -> LAP=1 and EN1HZ keeps its 10-cycle period. Press KEY[1] again -> LAP=0. Assert RST with LAP=1 mid-run -> all outputs go to 0 asynchronously.
